mmio_uart_tx: RTL

Memory-mapped UART transmitter on the single-cycle ARM core's data-memory port, beside `dmem`. It decodes the core's store address and queues bytes written to its DATA register into a small FIFO. It serialises each byte as an 8N1 frame on `tx`. It returns a combinational STATUS word on reads so the core can poll it with LDR in the same cycle.

---
 rtl/mmio_pkg.sv | 22 ++
 rtl/fifo_sync.sv | 67 ++++++
 rtl/mmio_uart_tx.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter:
// FSM encoding, register offsets and STATUS bit positions.
`timescale 1ns/1ps
package mmio_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam logic [2:0] UART_DATA_OFS   = 3'd0;
    localparam logic [2:0] UART_STATUS_OFS = 3'd4;

    localparam int STAT_FULL_BIT   = 0;
    localparam int STAT_EMPTY_BIT  = 1;
    localparam int STAT_BUSY_BIT   = 2;
    localparam int STAT_OVF_BIT    = 3;
    localparam int STAT_COUNT_LSB  = 8;

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with registered pointers and occupancy count.
// Push is ignored when full and pop is ignored when empty.
`timescale 1ns/1ps
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;

    // NOTE: every variable is given a default first so no path through the block leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; an entry is only read after it was written, and this lets it map to RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core's data port: DATA/STATUS
// decode, byte FIFO, sticky overflow flag and the serialiser FSM.
`timescale 1ns/1ps
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
    parameter int          CLKS_PER_BIT = 4,
    parameter int          DEPTH        = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Sel,
    output logic        tx
);

    localparam int CCW = $clog2(CLKS_PER_BIT);
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam logic [CCW-1:0] CLK_LAST = CCW'(CLKS_PER_BIT - 1);

    uart_state_t    state_q, state_d;
    logic [7:0]     shift_q, shift_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [CCW-1:0] clk_cnt_q, clk_cnt_d;
    logic           tx_q, tx_d;
    logic           overflow_q, overflow_d;

    logic           is_status, wr_data, wr_status;
    logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]     fifo_dout;
    logic [CW-1:0]  fifo_count;
    logic           bit_done;
    logic [31:0]    status;
    logic           unused_bits;

    assign unused_bits = ^{WriteData[31:8], WriteData[2:0], DataAdr[1:0]};

    assign Sel       = (DataAdr[31:3] == BASE_ADDR[31:3]);
    assign is_status = (DataAdr[2] == UART_STATUS_OFS[2]);
    assign wr_data   = Sel & MemWrite & ~is_status;
    assign wr_status = Sel & MemWrite & is_status;
    assign fifo_push = wr_data & ~fifo_full;

    fifo_sync #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (WriteData[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        status                              = '0;
        status[STAT_FULL_BIT]               = fifo_full;
        status[STAT_EMPTY_BIT]              = fifo_empty;
        status[STAT_BUSY_BIT]               = (state_q != IDLE);
        status[STAT_OVF_BIT]                = overflow_q;
        status[STAT_COUNT_LSB +: CW]        = fifo_count;
    end

    assign ReadData = (Sel && is_status) ? status : 32'h0;

    // A dropped byte sets the flag; only an explicit STATUS write clears it.
    always_comb begin
        overflow_d = overflow_q;
        if (wr_data && fifo_full)             overflow_d = 1'b1;
        else if (wr_status && WriteData[3])   overflow_d = 1'b0;
    end

    assign bit_done = (clk_cnt_q == CLK_LAST);

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        clk_cnt_d = bit_done ? '0 : clk_cnt_q + CCW'(1);
        fifo_pop  = 1'b0;
        tx_d      = 1'b1;
        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    state_d  = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (bit_done) begin
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (bit_done) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                // Popping on the last stop cycle makes back-to-back frames contiguous.
                if (bit_done) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        state_d  = START;
                    end else begin
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // tx is registered from the current state, so the line lags the FSM by one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            clk_cnt_q  <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            clk_cnt_q  <= clk_cnt_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx = tx_q;

endmodule
